// File: rtl/expr_eval_engine.sv
// Streaming shunting-yard evaluator for infix integer expressions.
// Two on-chip stacks, one reduction per cycle, iterative divide.
module expr_eval_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [3:0]       tok_kind,
  input  logic [WIDTH-1:0] tok_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_value,
  output logic [1:0]       res_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] K_END   = 4'd0;
  localparam logic [3:0] K_INT   = 4'd1;
  localparam logic [3:0] K_PLUS  = 4'd2;
  localparam logic [3:0] K_MINUS = 4'd3;
  localparam logic [3:0] K_MUL   = 4'd4;
  localparam logic [3:0] K_DIV   = 4'd5;
  localparam logic [3:0] K_MOD   = 4'd6;
  localparam logic [3:0] K_LPAR  = 4'd7;
  localparam logic [3:0] K_RPAR  = 4'd8;
  localparam logic [3:0] K_NOT   = 4'd9;
  localparam logic [3:0] K_TRUE  = 4'd10;
  localparam logic [3:0] K_FALSE = 4'd11;

  typedef enum logic [2:0] {
    S_ACCEPT, S_REDUCE, S_DIVIDE, S_OUT, S_SKIP
  } state_t;

  typedef enum logic [3:0] {
    O_ADD, O_SUB, O_MUL, O_DIV, O_MOD,
    O_LPAR, O_NOT, O_NEG, O_POS
  } op_t;

  function automatic logic [2:0] prec(input op_t o);
    unique case (o)
      O_NOT:               prec = 3'd1;
      O_ADD, O_SUB:        prec = 3'd2;
      O_MUL, O_DIV, O_MOD: prec = 3'd3;
      O_NEG, O_POS:        prec = 3'd4;
      default:             prec = 3'd0;
    endcase
  endfunction

  state_t           r_state, w_next;
  op_t              r_ostk [DEPTH];
  logic [WIDTH-1:0] r_nstk [DEPTH];
  logic [CW-1:0]    r_ocnt, r_ncnt;
  logic             r_expect;
  logic [3:0]       r_pend;
  logic             r_valid;
  logic [WIDTH-1:0] r_value;
  logic [1:0]       r_err;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_neg_q, r_neg_r, r_isdiv;
  logic [DW-1:0]    r_dcnt;

  logic [3:0]       w_kind;
  logic             w_fire;
  logic             w_is_opnd, w_is_bin, w_is_pre;
  logic             w_is_lpar, w_is_rpar, w_is_end;
  logic             w_illegal, w_syn, w_need, w_bar;
  op_t              w_new_op, w_top;
  logic [WIDTH-1:0] w_val, w_a, w_b, w_red_val;
  logic [IW-1:0]    w_oi0, w_oi1, w_ni0, w_ni1, w_ni2;
  logic [1:0]       w_cmp_err, w_red_err, w_err;
  logic             w_un_top, w_under, w_divop;
  logic             w_do_cmp, w_do_red;
  logic [WIDTH:0]   w_rsh, w_diff;
  logic [WIDTH-1:0] w_rem_n, w_quo_n, w_div_res;

  assign tok_ready = rst_n &
    ((r_state == S_ACCEPT) | (r_state == S_SKIP));
  assign res_valid = r_valid;
  assign res_value = r_value;
  assign res_err   = r_err;

  assign w_fire = tok_valid & tok_ready;
  assign w_kind = (r_state == S_ACCEPT) ? tok_kind : r_pend;

  assign w_oi0 = IW'(r_ocnt);
  assign w_oi1 = IW'(r_ocnt - CW'(1));
  assign w_ni0 = IW'(r_ncnt);
  assign w_ni1 = IW'(r_ncnt - CW'(1));
  assign w_ni2 = IW'(r_ncnt - CW'(2));
  assign w_top = r_ostk[w_oi1];
  assign w_a   = r_nstk[w_ni2];
  assign w_b   = r_nstk[w_ni1];

  always_comb begin
    w_is_opnd = 1'b0;
    w_is_bin  = 1'b0;
    w_is_pre  = 1'b0;
    w_is_lpar = 1'b0;
    w_is_rpar = 1'b0;
    w_is_end  = 1'b0;
    w_illegal = 1'b0;
    w_new_op  = O_ADD;
    unique case (1'b1)
      w_kind == K_END:   w_is_end = 1'b1;
      w_kind == K_INT,
      w_kind == K_TRUE,
      w_kind == K_FALSE: w_is_opnd = 1'b1;
      w_kind == K_PLUS: begin
        w_is_pre = r_expect;
        w_is_bin = !r_expect;
        w_new_op = r_expect ? O_POS : O_ADD;
      end
      w_kind == K_MINUS: begin
        w_is_pre = r_expect;
        w_is_bin = !r_expect;
        w_new_op = r_expect ? O_NEG : O_SUB;
      end
      w_kind == K_MUL: begin
        w_is_bin = 1'b1;
        w_new_op = O_MUL;
      end
      w_kind == K_DIV: begin
        w_is_bin = 1'b1;
        w_new_op = O_DIV;
      end
      w_kind == K_MOD: begin
        w_is_bin = 1'b1;
        w_new_op = O_MOD;
      end
      w_kind == K_LPAR: begin
        w_is_lpar = 1'b1;
        w_new_op  = O_LPAR;
      end
      w_kind == K_RPAR: w_is_rpar = 1'b1;
      w_kind == K_NOT: begin
        w_is_pre = 1'b1;
        w_new_op = O_NOT;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_val = '0;
    unique case (1'b1)
      tok_kind == K_INT:  w_val = tok_value;
      tok_kind == K_TRUE: w_val = WIDTH'(1);
      default:            w_val = '0;
    endcase
  end

  // Prefix operators never reduce: their left side is still open.
  assign w_bar = (r_ocnt != '0) && (w_top != O_LPAR);
  always_comb begin
    w_need = 1'b0;
    if (w_is_bin)
      w_need = w_bar && (prec(w_top) >= prec(w_new_op));
    else if (w_is_rpar || w_is_end)
      w_need = w_bar;
  end

  assign w_syn = w_illegal
    | (w_is_opnd & !r_expect)
    | ((w_is_bin | w_is_rpar | w_is_end) & r_expect);

  always_comb begin
    w_cmp_err = 2'd0;
    unique case (1'b1)
      w_is_opnd:
        if (r_ncnt == CW'(DEPTH)) w_cmp_err = 2'd1;
      w_is_bin | w_is_pre | w_is_lpar:
        if (r_ocnt == CW'(DEPTH)) w_cmp_err = 2'd1;
      w_is_rpar:
        if (r_ocnt == '0) w_cmp_err = 2'd3;
      w_is_end:
        if (r_ocnt != '0 || r_ncnt != CW'(1))
          w_cmp_err = 2'd3;
      default: w_cmp_err = 2'd0;
    endcase
  end

  assign w_un_top = (w_top == O_NOT) || (w_top == O_NEG)
                 || (w_top == O_POS);
  assign w_under  = w_un_top ? (r_ncnt < CW'(1))
                             : (r_ncnt < CW'(2));
  assign w_divop  = (w_top == O_DIV) || (w_top == O_MOD);

  always_comb begin
    w_red_err = 2'd0;
    if (w_under) w_red_err = 2'd3;
    else if (w_divop && w_b == '0) w_red_err = 2'd2;
  end

  always_comb begin
    w_red_val = '0;
    unique case (w_top)
      O_ADD:   w_red_val = w_a + w_b;
      O_SUB:   w_red_val = w_a - w_b;
      O_MUL:   w_red_val = w_a * w_b;
      O_NEG:   w_red_val = -w_b;
      O_POS:   w_red_val = w_b;
      O_NOT:   w_red_val = WIDTH'(w_b == '0);
      default: w_red_val = '0;
    endcase
  end

  always_comb begin
    w_err = 2'd0;
    if (r_state == S_ACCEPT && w_fire)
      w_err = w_syn ? 2'd3 : (w_need ? 2'd0 : w_cmp_err);
    else if (r_state == S_REDUCE)
      w_err = w_need ? w_red_err : w_cmp_err;
  end

  assign w_do_cmp = ((r_state == S_ACCEPT && w_fire)
                  || r_state == S_REDUCE)
                  && !w_need && w_err == 2'd0;
  assign w_do_red = r_state == S_REDUCE && w_need
                  && w_err == 2'd0;

  // Restoring step; sign fix-up folded into the final step.
  assign w_rsh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_rsh - {1'b0, r_dvs};
  assign w_rem_n = w_diff[WIDTH] ? w_rsh[WIDTH-1:0]
                                 : w_diff[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], !w_diff[WIDTH]};
  assign w_div_res = r_isdiv
    ? (r_neg_q ? -w_quo_n : w_quo_n)
    : (r_neg_r ? -w_rem_n : w_rem_n);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ACCEPT:
        if (w_fire) begin
          if (w_err != 2'd0)
            w_next = w_is_end ? S_OUT : S_SKIP;
          else if (w_need)
            w_next = S_REDUCE;
          else if (w_is_end)
            w_next = S_OUT;
        end
      S_REDUCE:
        if (w_err != 2'd0)
          w_next = w_is_end ? S_OUT : S_SKIP;
        else if (w_need)
          w_next = w_divop ? S_DIVIDE : S_REDUCE;
        else
          w_next = w_is_end ? S_OUT : S_ACCEPT;
      S_DIVIDE:
        if (r_dcnt == '0) w_next = S_REDUCE;
      S_OUT:
        if (res_ready) w_next = S_ACCEPT;
      S_SKIP:
        if (w_fire && tok_kind == K_END) w_next = S_OUT;
      default: w_next = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCEPT;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ocnt   <= '0;
      r_ncnt   <= '0;
      r_expect <= 1'b1;
      r_pend   <= '0;
      r_valid  <= 1'b0;
      r_value  <= '0;
      r_err    <= 2'd0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_isdiv  <= 1'b0;
      r_dcnt   <= '0;
    end else if (w_err != 2'd0) begin
      r_err  <= w_err;
      r_ocnt <= '0;
      r_ncnt <= '0;
      if (w_is_end) begin
        r_valid <= 1'b1;
        r_value <= '0;
      end
    end else begin
      if (r_state == S_ACCEPT && w_fire)
        r_pend <= tok_kind;
      if (w_do_cmp) begin
        unique case (1'b1)
          w_is_opnd: begin
            r_nstk[w_ni0] <= w_val;
            r_ncnt   <= r_ncnt + CW'(1);
            r_expect <= 1'b0;
          end
          w_is_bin | w_is_pre | w_is_lpar: begin
            r_ostk[w_oi0] <= w_new_op;
            r_ocnt   <= r_ocnt + CW'(1);
            r_expect <= 1'b1;
          end
          w_is_rpar: begin
            r_ocnt   <= r_ocnt - CW'(1);
            r_expect <= 1'b0;
          end
          w_is_end: begin
            r_valid <= 1'b1;
            r_value <= r_nstk[0];
          end
          default: ;
        endcase
      end
      if (w_do_red) begin
        r_ocnt <= r_ocnt - CW'(1);
        if (w_divop) begin
          r_ncnt  <= r_ncnt - CW'(2);
          r_quo   <= w_a[WIDTH-1] ? -w_a : w_a;
          r_dvs   <= w_b[WIDTH-1] ? -w_b : w_b;
          r_rem   <= '0;
          r_neg_q <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
          r_neg_r <= w_a[WIDTH-1];
          r_isdiv <= (w_top == O_DIV);
          r_dcnt  <= DW'(WIDTH - 1);
        end else if (w_un_top) begin
          r_nstk[w_ni1] <= w_red_val;
        end else begin
          r_nstk[w_ni2] <= w_red_val;
          r_ncnt <= r_ncnt - CW'(1);
        end
      end
      if (r_state == S_DIVIDE) begin
        r_rem  <= w_rem_n;
        r_quo  <= w_quo_n;
        r_dcnt <= r_dcnt - DW'(1);
        if (r_dcnt == '0) begin
          r_nstk[w_ni0] <= w_div_res;
          r_ncnt <= r_ncnt + CW'(1);
        end
      end
      if (r_state == S_OUT && res_ready) begin
        r_valid  <= 1'b0;
        r_value  <= '0;
        r_err    <= 2'd0;
        r_ocnt   <= '0;
        r_ncnt   <= '0;
        r_expect <= 1'b1;
      end
      if (r_state == S_SKIP && w_fire && tok_kind == K_END) begin
        r_valid <= 1'b1;
        r_value <= '0;
      end
    end
  end

endmodule
